// File: rtl/count_bits_seq.sv
// count_bits_seq: sequential ones/zeros/leading-zero/trailing-zero counter
// scanning STEP bits per cycle, with a start/busy/done handshake.
module count_bits_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int STEP        = 4,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bit_count
);
  localparam int NCH = DATA_WIDTH / STEP;
  localparam int IW  = $clog2(NCH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  temp_q, temp_d, shifted;
  logic [1:0]             mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, bit_count_q, bit_count_d;
  logic [COUNT_WIDTH-1:0] pop, lz, tz, add;
  logic [IW-1:0]          idx_q, idx_d;
  logic [STEP-1:0]        lo, hi;
  logic                   lo_seen, hi_seen, last, fin;
  assign lo = temp_q[STEP-1:0];
  assign hi = temp_q[DATA_WIDTH-1 -: STEP];
  // Per-chunk counts; a chunk with no 1 yields STEP for both zero runs.
  always_comb begin
    pop     = '0;
    lz      = '0;
    tz      = '0;
    lo_seen = 1'b0;
    hi_seen = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      pop     = pop + COUNT_WIDTH'(lo[i]);
      lo_seen = lo_seen | lo[i];
      tz      = tz + COUNT_WIDTH'(!lo_seen);
      hi_seen = hi_seen | hi[STEP-1-i];
      lz      = lz + COUNT_WIDTH'(!hi_seen);
    end
  end
  assign add     = mode_q == 2'b00 ? pop : mode_q == 2'b01 ? COUNT_WIDTH'(STEP) - pop :
                   mode_q[0] ? tz : lz;
  assign shifted = mode_q == 2'b10 ? temp_q << STEP : temp_q >> STEP;
  assign last    = idx_q == IW'(NCH - 1);
  assign fin     = last | (mode_q == 2'b00 && shifted == '0) |
                   (mode_q == 2'b10 && |hi) | (mode_q == 2'b11 && |lo);
  always_comb begin
    state_d     = state_q;
    temp_d      = temp_q;
    mode_d      = mode_q;
    count_d     = count_q;
    idx_d       = idx_q;
    bit_count_d = bit_count_q;
    case (state_q)
      RUN: begin
        temp_d  = shifted;
        count_d = count_q + add;
        idx_d   = idx_q + 1'b1;
        if (fin) begin
          state_d     = DONE;
          bit_count_d = count_q + add;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          temp_d  = data;
          mode_d  = mode;
          count_d = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      temp_q      <= '0;
      mode_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      temp_q      <= temp_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      bit_count_q <= bit_count_d;
    end
  end
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign bit_count = bit_count_q;
endmodule
